// File: rtl/voice_mixer_n.sv
// rtl/voice_mixer_n.sv - parametrised stereo voice mixer with pan, ramped master volume and saturation
//
// Ports:
//   sCLK_XVXENVS  clock
//   reset_data_N  asynchronous active-low reset
//   smp_*         one oscillator sample per cycle (valid, voice, osc, envelope level, sine value)
//   mute          forces the master-volume ramp target to zero
//   reg_*         parameter write port into the shadow set
//                 (osc register: osc*16+2 level, osc*16+7 pan; common register: 1 = master volume)
//   lsound_out, rsound_out, clip_l, clip_r, out_valid   one mixed stereo sample per frame
module voice_mixer_n #(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 4,
  parameter int AUDIO_W   = 24,
  parameter int ACC_W     = 48,
  parameter int OUT_SHIFT = 26,
  parameter int VW        = (VOICES > 1) ? $clog2(VOICES) : 1,
  parameter int OW        = (V_OSC > 1) ? $clog2(V_OSC) : 1
) (
  input  logic                      sCLK_XVXENVS,
  input  logic                      reset_data_N,
  input  logic                      smp_valid,
  input  logic [VW-1:0]             smp_voice,
  input  logic [OW-1:0]             smp_osc,
  input  logic signed [7:0]         smp_level,
  input  logic signed [16:0]        smp_sine,
  input  logic                      mute,
  input  logic                      reg_we,
  input  logic                      reg_com,
  input  logic [OW+3:0]             reg_adr,
  input  logic signed [7:0]         reg_wdata,
  output logic signed [AUDIO_W-1:0] lsound_out,
  output logic signed [AUDIO_W-1:0] rsound_out,
  output logic                      out_valid,
  output logic                      clip_l,
  output logic                      clip_r
);

  localparam int FW = ACC_W + 8;
  localparam logic [VW:0] VOICES_W = (VW+1)'(VOICES);
  localparam logic [OW:0] V_OSC_W  = (OW+1)'(V_OSC);
  localparam logic signed [FW-1:0] SAT_MAX = (FW'(1) <<< (AUDIO_W-1)) - FW'(1);
  localparam logic signed [FW-1:0] SAT_MIN = -SAT_MAX - FW'(1);

  // shadow (written by the register port) and active (used by the datapath) parameter sets
  logic signed [7:0] lvl_sh  [V_OSC];
  logic signed [7:0] pan_sh  [V_OSC];
  logic signed [7:0] lvl_act [V_OSC];
  logic signed [7:0] pan_act [V_OSC];
  logic signed [7:0] m_vol_sh;
  logic signed [7:0] m_vol_cur;
  logic signed [7:0] m_vol_tgt;

  // pipeline registers
  logic                    s0_vld, s0_last, s1_vld, s1_last, s2_vld, s2_last;
  logic [OW-1:0]           s0_osc, s1_osc, s2_osc;
  logic signed [7:0]       s0_level;
  logic signed [16:0]      s0_sine;
  logic signed [24:0]      s1_p1;
  logic signed [32:0]      s2_p2;
  logic signed [ACC_W-1:0] acc_l, acc_r, tot_l, tot_r;
  logic                    tot_vld, f1_vld;
  logic signed [FW-1:0]    f1_l, f1_r;

  logic                    accept, is_last;
  logic signed [7:0]       pan_raw;
  logic [6:0]              pan_c, w_l;
  logic signed [40:0]      prod_l, prod_r;
  logic signed [ACC_W-1:0] sum_l, sum_r;
  logic signed [FW-1:0]    sh_l, sh_r;
  logic [AUDIO_W:0]        sat_l, sat_r;

  function automatic logic [AUDIO_W:0] saturate(input logic signed [FW-1:0] v);
    logic [AUDIO_W:0] r;
    if (v > SAT_MAX)      r = {1'b1, SAT_MAX[AUDIO_W-1:0]};
    else if (v < SAT_MIN) r = {1'b1, SAT_MIN[AUDIO_W-1:0]};
    else                  r = {1'b0, v[AUDIO_W-1:0]};
    return r;
  endfunction

  assign accept  = smp_valid && ({1'b0, smp_voice} < VOICES_W);
  assign is_last = (smp_voice == VW'(VOICES-1)) && (smp_osc == OW'(V_OSC-1));

  // negative pan reads as hard left
  assign pan_raw = pan_act[s2_osc];
  assign pan_c   = pan_raw[7] ? 7'd0 : pan_raw[6:0];
  assign w_l     = 7'd127 - pan_c;
  assign prod_l  = 41'(s2_p2) * 41'($signed({2'b00, w_l}));
  assign prod_r  = 41'(s2_p2) * 41'($signed({2'b00, pan_c}));
  assign sum_l   = acc_l + ACC_W'(prod_l);
  assign sum_r   = acc_r + ACC_W'(prod_r);

  assign sh_l  = f1_l >>> OUT_SHIFT;
  assign sh_r  = f1_r >>> OUT_SHIFT;
  assign sat_l = saturate(sh_l);
  assign sat_r = saturate(sh_r);

  // the ramp aims at the master volume that becomes active with this frame's load
  assign m_vol_tgt = mute ? 8'sh00 : m_vol_sh;

  always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
    if (!reset_data_N) begin
      for (int i = 0; i < V_OSC; i++) begin
        lvl_sh[i] <= (i < 2) ? 8'sh40 : 8'sh00;
        pan_sh[i] <= 8'sh40;
      end
      m_vol_sh <= 8'sh40;
    end else if (reg_we) begin
      if (reg_com) begin
        if (reg_adr == (OW+4)'(1)) m_vol_sh <= reg_wdata;
      end else if ({1'b0, reg_adr[OW+3:4]} < V_OSC_W) begin
        case (reg_adr[3:0])
          4'd2:    lvl_sh[reg_adr[OW+3:4]] <= reg_wdata;
          4'd7:    pan_sh[reg_adr[OW+3:4]] <= reg_wdata;
          default: ;
        endcase
      end
    end
  end

  // active set and volume ramp advance together with the output strobe
  always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
    if (!reset_data_N) begin
      for (int i = 0; i < V_OSC; i++) begin
        lvl_act[i] <= (i < 2) ? 8'sh40 : 8'sh00;
        pan_act[i] <= 8'sh40;
      end
      m_vol_cur <= 8'sh40;
    end else if (f1_vld) begin
      lvl_act <= lvl_sh;
      pan_act <= pan_sh;
      if (m_vol_cur < m_vol_tgt)      m_vol_cur <= m_vol_cur + 8'sd1;
      else if (m_vol_cur > m_vol_tgt) m_vol_cur <= m_vol_cur - 8'sd1;
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
    if (!reset_data_N) begin
      s0_vld <= 1'b0;  s0_last <= 1'b0; s0_osc <= '0; s0_level <= '0; s0_sine <= '0;
      s1_vld <= 1'b0;  s1_last <= 1'b0; s1_osc <= '0; s1_p1 <= '0;
      s2_vld <= 1'b0;  s2_last <= 1'b0; s2_osc <= '0; s2_p2 <= '0;
      acc_l <= '0;     acc_r <= '0;     tot_l <= '0;  tot_r <= '0; tot_vld <= 1'b0;
      f1_l <= '0;      f1_r <= '0;      f1_vld <= 1'b0;
      lsound_out <= '0; rsound_out <= '0; out_valid <= 1'b0; clip_l <= 1'b0; clip_r <= 1'b0;
    end else begin
      s0_vld   <= accept;
      s0_last  <= accept && is_last;
      s0_osc   <= smp_osc;
      s0_level <= smp_level;
      s0_sine  <= smp_sine;

      s1_vld  <= s0_vld;
      s1_last <= s0_last;
      s1_osc  <= s0_osc;
      s1_p1   <= 25'(s0_level) * 25'(s0_sine);

      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s2_osc  <= s1_osc;
      s2_p2   <= 33'(s1_p1) * 33'(lvl_act[s1_osc]);

      // the frame total is parked in tot_* so the accumulator restarts from zero
      // and the next frame's first sample can accumulate on the very next cycle
      tot_vld <= s2_vld && s2_last;
      if (s2_vld) begin
        if (s2_last) begin
          tot_l <= sum_l;
          tot_r <= sum_r;
          acc_l <= '0;
          acc_r <= '0;
        end else begin
          acc_l <= sum_l;
          acc_r <= sum_r;
        end
      end

      f1_vld <= tot_vld;
      if (tot_vld) begin
        f1_l <= FW'(tot_l) * FW'(m_vol_cur);
        f1_r <= FW'(tot_r) * FW'(m_vol_cur);
      end

      out_valid <= f1_vld;
      if (f1_vld) begin
        lsound_out <= sat_l[AUDIO_W-1:0];
        rsound_out <= sat_r[AUDIO_W-1:0];
        clip_l     <= sat_l[AUDIO_W];
        clip_r     <= sat_r[AUDIO_W];
      end
    end
  end

endmodule

// File: tb/tb_voice_mixer_n.sv
// tb/tb_voice_mixer_n.sv - scoreboard bench for voice_mixer_n at default parameters
module tb_voice_mixer_n;

  logic               clk = 1'b0;
  logic               reset_data_N = 1'b0;
  logic               smp_valid = 1'b0;
  logic [2:0]         smp_voice = '0;
  logic [1:0]         smp_osc = '0;
  logic signed [7:0]  smp_level = '0;
  logic signed [16:0] smp_sine = '0;
  logic               mute = 1'b0;
  logic               reg_we = 1'b0;
  logic               reg_com = 1'b0;
  logic [5:0]         reg_adr = '0;
  logic signed [7:0]  reg_wdata = '0;
  logic signed [23:0] lsound_out, rsound_out;
  logic               out_valid, clip_l, clip_r;

  voice_mixer_n dut (
    .sCLK_XVXENVS(clk), .reset_data_N(reset_data_N),
    .smp_valid(smp_valid), .smp_voice(smp_voice), .smp_osc(smp_osc),
    .smp_level(smp_level), .smp_sine(smp_sine), .mute(mute),
    .reg_we(reg_we), .reg_com(reg_com), .reg_adr(reg_adr), .reg_wdata(reg_wdata),
    .lsound_out(lsound_out), .rsound_out(rsound_out), .out_valid(out_valid),
    .clip_l(clip_l), .clip_r(clip_r)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    l;
    int    r;
    bit    cl;
    bit    cr;
    int    cyc;
    string name;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   nvec = 0;
  int   nfail = 0;

  // monitor: every out_valid must match the oldest outstanding expectation, on time
  initial begin
    forever begin
      @(negedge clk);
      if (reset_data_N && out_valid) begin
        nvec++;
        if (sbq.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_out_valid at cycle %0d: L=%0d R=%0d", cyc, lsound_out, rsound_out);
        end else begin
          me = sbq.pop_front();
          if (lsound_out !== 24'(me.l) || rsound_out !== 24'(me.r) ||
              clip_l !== me.cl || clip_r !== me.cr || cyc != me.cyc)
          begin
            nfail++;
            $display("FAIL %s: got L=%0d R=%0d cl=%b cr=%b cyc=%0d, expected L=%0d R=%0d cl=%b cr=%b cyc=%0d",
                     me.name, lsound_out, rsound_out, clip_l, clip_r, cyc,
                     me.l, me.r, me.cl, me.cr, me.cyc);
          end
        end
      end
    end
  end

  task automatic drive(input bit vld, input int v, input int o, input int l, input int s);
    @(negedge clk);
    smp_valid = vld;
    smp_voice = 3'(v);
    smp_osc   = 2'(o);
    smp_level = 8'(l);
    smp_sine  = 17'(s);
    reg_we    = 1'b0;
  endtask

  task automatic smp(input int v, input int o, input int l, input int s);
    drive(1'b1, v, o, l, s);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int adr, input int d);
    @(negedge clk);
    smp_valid = 1'b0;
    reg_we    = 1'b1;
    reg_com   = 1'b0;
    reg_adr   = 6'(adr);
    reg_wdata = 8'(d);
  endtask

  // last sample of a frame; the output is due 6 counted edges after this drive
  task automatic frame_end(input string nm, input int el, input int er, input bit ecl, input bit ecr);
    exp_t e;
    drive(1'b1, 7, 3, 0, 0);
    e.l = el; e.r = er; e.cl = ecl; e.cr = ecr; e.cyc = cyc + 6; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic check_now(input string nm, input int el, input int er, input bit eov,
                           input bit ecl, input bit ecr, input bit use_clip);
    nvec++;
    if (lsound_out !== 24'(el) || rsound_out !== 24'(er) || out_valid !== eov ||
        (use_clip && (clip_l !== ecl || clip_r !== ecr))) begin
      nfail++;
      $display("FAIL %s: got L=%0d R=%0d ov=%b cl=%b cr=%b, expected L=%0d R=%0d ov=%b cl=%b cr=%b",
               nm, lsound_out, rsound_out, out_valid, clip_l, clip_r, el, er, eov, ecl, ecr);
    end
  endtask

  initial begin
    int vol;
    int el, er;

    repeat (3) @(negedge clk);
    check_now("reset_state", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_data_N = 1'b1;
    nop(2);

    // default gains: level 64, pan 64 (L weight 63, R 64), volume 64
    smp(0, 0, 100, 10000);
    frame_end("single", 3845, 3906, 1'b0, 1'b0);
    nop(8);

    // three complete frames with no gap; only osc 0/1 carry gain
    for (int f = 0; f < 3; f++)
      for (int v = 0; v < 8; v++)
        for (int o = 0; o < 4; o++)
          if (v == 7 && o == 3) frame_end("b2b", 61523, 62500, 1'b0, 1'b0);
          else                  smp(v, o, 100, 10000);
    nop(8);

    // negative product floors under the arithmetic shift; invalid cycle ignored
    smp(3, 1, -100, 10000);
    drive(1'b0, 0, 0, 100, 10000);
    frame_end("negative", -3846, -3907, 1'b0, 1'b0);
    nop(8);

    // pan writes only take effect the frame after the next frame end
    wr(7, 0);
    smp(0, 0, 100, 10000); frame_end("pan0_shadow", 3845, 3906, 1'b0, 1'b0); nop(8);
    smp(0, 0, 100, 10000); frame_end("pan0", 7751, 0, 1'b0, 1'b0); nop(8);
    wr(7, -128);
    smp(0, 0, 100, 10000); frame_end("pan_neg_shadow", 7751, 0, 1'b0, 1'b0); nop(8);
    smp(0, 0, 100, 10000); frame_end("pan_neg", 7751, 0, 1'b0, 1'b0); nop(8);
    wr(7, 127);
    smp(0, 0, 100, 10000); frame_end("pan127_shadow", 7751, 0, 1'b0, 1'b0); nop(8);
    smp(0, 0, 100, 10000); frame_end("pan127", 0, 7751, 1'b0, 1'b0); nop(8);
    wr(7, 64);
    smp(0, 0, 100, 10000); frame_end("pan64_shadow", 0, 7751, 1'b0, 1'b0); nop(8);

    // saturation both ways
    repeat (300) smp(0, 0, 127, 65535);
    frame_end("sat_pos", 8388607, 8388607, 1'b1, 1'b1);
    nop(8);
    repeat (300) smp(0, 0, 127, -65535);
    frame_end("sat_neg", -8388608, -8388608, 1'b1, 1'b1);
    nop(8);
    check_now("hold", -8388608, -8388608, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset while a frame end and a partial frame are in flight
    smp(0, 0, 100, 10000);
    drive(1'b1, 7, 3, 0, 0);
    smp(0, 0, 100, 10000);
    @(negedge clk);
    #2 reset_data_N = 1'b0;
    #1 check_now("reset_mid", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    smp_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_data_N = 1'b1;
    nop(2);
    smp(0, 0, 100, 10000);
    frame_end("after_reset", 3845, 3906, 1'b0, 1'b0);
    nop(8);

    // level write in the middle of a frame
    smp(0, 0, 100, 10000);
    wr(2, 32);
    smp(0, 0, 100, 10000);
    frame_end("lvl_old", 7690, 7812, 1'b0, 1'b0);
    nop(8);
    smp(0, 0, 100, 10000);
    smp(0, 0, 100, 10000);
    frame_end("lvl_new", 3845, 3906, 1'b0, 1'b0);
    nop(8);

    // mute: frame k is mixed at volume 65-k, then silence
    mute = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      vol = (k <= 65) ? 65 - k : 0;
      el = int'((longint'(1000000) * 32 * 63 * vol) >>> 26);
      er = int'((longint'(1000000) * 32 * 64 * vol) >>> 26);
      smp(0, 0, 100, 10000);
      frame_end($sformatf("mute_f%0d", k), el, er, 1'b0, 1'b0);
    end
    nop(8);

    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    while (sbq.size() != 0) begin
      me = sbq.pop_front();
      nvec++;
      nfail++;
      $display("FAIL %s: no out_valid seen, expected L=%0d R=%0d", me.name, me.l, me.r);
    end
    nop(10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
